hms_display_scanner: RTL and testbench
======================================

# hms_display_scanner

Reader-side consumer of the 24-hour time bus (`seconds`, `minutes`, `hours`) driven by the time-of-day counter. It converts the binary time to six BCD digits (HH MM SS) and drives a time-multiplexed, common-anode 6-digit 7-segment display. A prescaler paces the digit scan. Time is snapshotted once per scan frame, so one frame never shows a torn value. Out-of-range fields are shown as dashes.

## Interface

- `SCAN_DIV`, 1000: clk cycles each digit stays lit. Legal range 2..65535.
- `clk`  in  1  system clock. Same clock as the time counter.
- `reset`  in  1  asynchronous, active-high.
- `seconds`  in  6  binary seconds. Valid range 0..59.
- `minutes`  in  6  binary minutes. Valid range 0..59.
- `hours`  in  5  binary hours. Valid range 0..23.
- `blank`  in  1  synchronous display blank. While high, `an` is all ones. Scanning continues.
- `seg`  out  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
- `dp`  out  1  colon dot, active-high.
- `an`  out  6  digit enable, active-low, one-hot. Bit 0 = hours tens (leftmost); bit 5 = seconds units.
- `frame_start`  out  1  one-cycle pulse when digit 0 begins showing a new snapshot.

## Operation

- **Prescaler `p`.** Counts 0..SCAN_DIV-1. `tick` is asserted when `p == SCAN_DIV-1`. On `tick`, `p` wraps to 0.
- **Digit index `idx`.** Takes values 0..5 and advances on `tick`. From 5 it wraps to 0.
- **Snapshot registers `sh`, `sm`, `ss`.** Loaded from the inputs when either:
  - `primed == 0`, or
  - `tick && idx == 5`.
  
  `primed` is set by the first load and stays set until reset. Inputs are not sampled at any other time.
- **Binary-to-BCD conversion.** Combinational, on the snapshot values:
  - tens = v/10, units = v%10.
  - Tens is at most 5 for minutes and seconds, and at most 2 for hours.
- **Range check.** A field is in error if `ss > 59`, `sm > 59` or `sh > 23`. Both digits of an errored field show a dash: `seg = 7'h40`. Other fields are unaffected.
- **Segment map.** Digits 0..9 map to: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
- **Colon (`dp`).** `dp = 1` on digits 1 and 3 when `ss[0] == 0`. Otherwise `dp = 0`, including when the seconds field is in error.
- **Digit enable.** `an = ~(6'b1 << idx)` when `blank == 0`, and `6'b111111` when `blank == 1`.
- **Unlit digit.** While `blank` is high, `seg` and `dp` still track `idx`. They are not forced to zero.

## Timing

- **Registered outputs.** `seg`, `dp`, `an` and `frame_start` are all registered. They reflect the `idx`, snapshot and `blank` values from one cycle earlier.
- **Reset values.**
  - `p = 0`, `idx = 0`, `primed = 0`, snapshots = 0.
  - `seg = 0`, `dp = 0`, `an = 6'b111111`, `frame_start = 0`.
- **After reset deassert.**
  - Edge 1: snapshot loads and `primed` is set.
  - Edge 2: outputs show digit 0 of the loaded time, and `frame_start = 1` for exactly one cycle.
- **Steady state.**
  - The frame is 6 × SCAN_DIV cycles. Each digit is lit for exactly SCAN_DIV consecutive cycles.
  - `frame_start` pulses in the first cycle that `an == 6'b111110` after a wrap.
- **Simultaneous events.** If an input changes in the same cycle as the snapshot load, the value present at that edge is captured. The new value appears only in the following frame.
- **`blank` latency.** `blank` takes effect on `an` one cycle after it changes. `p`, `idx`, the snapshot and `frame_start` are unaffected by `blank`.
- **Reset mid-frame.** All state returns to reset values immediately (asynchronous). The priming sequence restarts on deassert.

## Test plan

All scenarios use `SCAN_DIV = 4`.

- **Reset and priming.**
  - Stimulus: inputs 13:45:08; release reset.
  - While reset is high: `an = 3F`, `seg = 0`.
  - Cycle 2 after release: `an = 3E`, `seg = 06` ("1"), `frame_start = 1`.
  - Digit 1 shows `seg = 4F`, `dp = 1`.
  - Digits 2..5 show 66, 6D, 3F, 7F.
- **Scan timing.**
  - Each `an` value holds for 4 cycles.
  - Sequence: 3E, 3D, 3B, 37, 2F, 1F, 3E.
  - `frame_start` repeats every 24 cycles.
- **Snapshot coherency.**
  - Stimulus: change the inputs from 13:45:08 to 13:45:09 while `idx == 2`.
  - Required: the current frame still ends with "08".
  - The next frame shows "09" with `dp = 0` on digits 1 and 3.
- **Rollover.**
  - Stimulus: inputs 23:59:59, then 00:00:00.
  - Required: successive frames show `seg` 5B,4F,6D,6F,6D,6F, then six × 3F. `dp = 1` in the 00:00:00 frame.
- **Range error.**
  - Stimulus: hours = 25, minutes = 60, seconds = 7.
  - Required: digits 0..3 show `seg = 40`; digits 4 and 5 show 3F and 07; `dp = 0`.
- **Blank and mid-frame reset.**
  - Stimulus: hold `blank = 1` for 10 cycles.
  - Required: `an = 3F` from one cycle after assert until one cycle after release. `idx` keeps advancing, so the post-release digit matches the elapsed-cycle count.
  - Stimulus: assert reset while `idx == 3`.
  - Required: all outputs return to reset values immediately, and priming repeats.

Source files
------------

// File: rtl/hms_display_scanner.sv
// Scans a 24-hour binary time (HH MM SS) onto a multiplexed common-anode
// 6-digit 7-segment display, snapshotting the time once per scan frame.
module hms_display_scanner #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_start
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] p_reg;
    logic [2:0]    idx_reg;
    logic          primed_reg;
    logic          fresh_reg;
    logic [4:0]    sh_reg;
    logic [5:0]    sm_reg;
    logic [5:0]    ss_reg;
    logic [6:0]    seg_reg;
    logic          dp_reg;
    logic [5:0]    an_reg;
    logic          frame_start_reg;

    logic          tick;
    logic          load;
    logic [6:0]    seg_next;
    logic          dp_next;
    logic [5:0]    an_next;
    logic [3:0]    digit;
    logic          dash;

    logic [2:0][5:0] fld;
    logic [2:0][3:0] tens;
    logic [2:0][3:0] units;
    logic [2:0]      err;

    assign tick = (p_reg == PW'(SCAN_DIV - 1));
    assign load = !primed_reg || (tick && idx_reg == 3'd5);

    assign fld[0] = {1'b0, sh_reg};
    assign fld[1] = sm_reg;
    assign fld[2] = ss_reg;

    // Field 0 is hours (limit 23); fields 1 and 2 are minutes and seconds.
    for (genvar gi = 0; gi < 3; gi++) begin : g_field
        localparam logic [5:0] LIMIT = (gi == 0) ? 6'd23 : 6'd59;
        assign err[gi]   = (fld[gi] > LIMIT);
        assign tens[gi]  = 4'(fld[gi] / 6'd10);
        assign units[gi] = 4'(fld[gi] % 6'd10);
    end

    always_comb begin
        digit = 4'd0;
        dash  = 1'b0;
        case (idx_reg)
            3'd0: begin digit = tens[0];  dash = err[0]; end
            3'd1: begin digit = units[0]; dash = err[0]; end
            3'd2: begin digit = tens[1];  dash = err[1]; end
            3'd3: begin digit = units[1]; dash = err[1]; end
            3'd4: begin digit = tens[2];  dash = err[2]; end
            3'd5: begin digit = units[2]; dash = err[2]; end
            default: ;
        endcase

        case (digit)
            4'd0:    seg_next = 7'h3F;
            4'd1:    seg_next = 7'h06;
            4'd2:    seg_next = 7'h5B;
            4'd3:    seg_next = 7'h4F;
            4'd4:    seg_next = 7'h66;
            4'd5:    seg_next = 7'h6D;
            4'd6:    seg_next = 7'h7D;
            4'd7:    seg_next = 7'h07;
            4'd8:    seg_next = 7'h7F;
            4'd9:    seg_next = 7'h6F;
            default: seg_next = 7'h00;
        endcase
        if (dash)
            seg_next = 7'h40;

        dp_next = (idx_reg == 3'd1 || idx_reg == 3'd3) && !ss_reg[0] && !err[2];
        an_next = blank ? 6'b111111 : ~(6'b000001 << idx_reg);
    end

    // The prescaler idles until the first snapshot so the first digit 0 gets a full slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_reg           <= '0;
            idx_reg         <= 3'd0;
            primed_reg      <= 1'b0;
            fresh_reg       <= 1'b0;
            sh_reg          <= '0;
            sm_reg          <= '0;
            ss_reg          <= '0;
            seg_reg         <= 7'h00;
            dp_reg          <= 1'b0;
            an_reg          <= 6'b111111;
            frame_start_reg <= 1'b0;
        end else begin
            if (primed_reg) begin
                p_reg <= tick ? '0 : p_reg + PW'(1);
                if (tick)
                    idx_reg <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
                seg_reg         <= seg_next;
                dp_reg          <= dp_next;
                an_reg          <= an_next;
                frame_start_reg <= fresh_reg;
            end
            if (load) begin
                sh_reg     <= hours;
                sm_reg     <= minutes;
                ss_reg     <= seconds;
                primed_reg <= 1'b1;
            end
            fresh_reg <= load;
        end
    end

    assign seg         = seg_reg;
    assign dp          = dp_reg;
    assign an          = an_reg;
    assign frame_start = frame_start_reg;
endmodule

// File: tb/tb_hms_display_scanner.sv
// Scoreboard bench for hms_display_scanner with SCAN_DIV = 4.
`timescale 1ns/1ps
module tb_hms_display_scanner;
    logic       clk;
    logic       reset;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       blank;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_start;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    hms_display_scanner #(.SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes),
        .hours(hours), .blank(blank), .seg(seg), .dp(dp), .an(an),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_frame(input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                              input logic [6:0] d3, input logic [6:0] d4, input logic [6:0] d5,
                              input logic dpx);
        logic [6:0] d[6];
        exp_t e;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3; d[4] = d4; d[5] = d5;
        for (int i = 0; i < 6; i++) begin
            e.an  = ~(6'b000001 << i);
            e.seg = d[i];
            e.dp  = (i == 1 || i == 3) ? dpx : 1'b0;
            exp_q.push_back(e);
        end
        $display("push frame %h %h %h %h %h %h dp=%0d", d0, d1, d2, d3, d4, d5, dpx);
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_start) return;
        end
        chk("wait_frame_start_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_an(input logic [5:0] val);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (an == val) return;
        end
        chk("wait_an_timeout", 32'(an), 32'(val));
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        hours = h; minutes = m; seconds = s;
    endtask

    // Monitor: pops one expectation whenever a new digit is lit, checks digit
    // hold time, frame_start placement and frame period.
    logic [5:0] prev_an = 6'h3F;
    int         run_len = 0;
    int         gap     = 0;
    bit         have_fs = 1'b0;
    initial begin
        exp_t e;
        bit   changed;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_an = 6'h3F; run_len = 0; gap = 0; have_fs = 1'b0;
            end else begin
                changed = (an != prev_an);
                if (mon_en) begin
                    chk("frame_start_place", 32'(frame_start), 32'(changed && an == 6'h3E));
                    if (changed && an != 6'h3F) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_digit", 32'(an), 32'h3F);
                        end else begin
                            e = exp_q.pop_front();
                            chk("digit_an", 32'(an), 32'(e.an));
                            chk("digit_seg", 32'(seg), 32'(e.seg));
                            chk("digit_dp", 32'(dp), 32'(e.dp));
                            $display("digit an=%h seg=%h dp=%0d fs=%0d", an, seg, dp, frame_start);
                        end
                        if (prev_an != 6'h3F)
                            chk("digit_hold", 32'(run_len), 32'd4);
                    end
                    if (frame_start) begin
                        if (have_fs)
                            chk("frame_period", 32'(gap), 32'd24);
                        have_fs = 1'b1;
                    end
                end
                if (changed) run_len = 0;
                if (frame_start) gap = 0;
                run_len++;
                gap++;
                prev_an = an;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        blank = 1'b0;
        set_time(5'd13, 6'd45, 6'd8);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_an", 32'(an), 32'h3F);
        chk("reset_seg", 32'(seg), 32'h00);
        chk("reset_dp", 32'(dp), 32'd0);
        chk("reset_fs", 32'(frame_start), 32'd0);

        // Frame 1 (priming) and frame 2 both carry 13:45:08.
        push_frame(7'h06, 7'h4F, 7'h66, 7'h6D, 7'h3F, 7'h7F, 1'b1);
        push_frame(7'h06, 7'h4F, 7'h66, 7'h6D, 7'h3F, 7'h7F, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk("prime_edge1_an", 32'(an), 32'h3F);
        @(negedge clk);
        chk("prime_edge2_an", 32'(an), 32'h3E);
        chk("prime_edge2_seg", 32'(seg), 32'h06);
        chk("prime_edge2_fs", 32'(frame_start), 32'd1);

        // Change to :09 mid-frame; only the next frame may show it.
        wait_fs();
        wait_an(6'h3B);
        set_time(5'd13, 6'd45, 6'd9);
        push_frame(7'h06, 7'h4F, 7'h66, 7'h6D, 7'h3F, 7'h6F, 1'b0);

        wait_fs();
        set_time(5'd23, 6'd59, 6'd59);
        push_frame(7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F, 1'b0);

        wait_fs();
        set_time(5'd0, 6'd0, 6'd0);
        push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);

        wait_fs();
        set_time(5'd25, 6'd60, 6'd7);
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h07, 1'b0);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        // Blank for 10 cycles starting in the first cycle of digit 0.
        wait_fs();
        blank = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("blank_an", 32'(an), 32'h3F);
            if (k == 10) blank = 1'b0;
        end
        @(negedge clk);
        chk("blank_release_an", 32'(an), 32'h3B);
        $display("blank released an=%h", an);

        // Asynchronous reset while digit 3 is lit, then re-prime.
        wait_an(6'h37);
        reset = 1'b1;
        #1;
        chk("midreset_an", 32'(an), 32'h3F);
        chk("midreset_seg", 32'(seg), 32'h00);
        chk("midreset_dp", 32'(dp), 32'd0);
        chk("midreset_fs", 32'(frame_start), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reprime_edge1_an", 32'(an), 32'h3F);
        @(negedge clk);
        chk("reprime_edge2_an", 32'(an), 32'h3E);
        chk("reprime_edge2_seg", 32'(seg), 32'h40);
        chk("reprime_edge2_fs", 32'(frame_start), 32'd1);
        @(negedge clk);
        chk("reprime_fs_one_cycle", 32'(frame_start), 32'd0);
        $display("reprimed an=%h seg=%h", an, seg);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
